// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder-subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter needs at least one bit even when a single digit covers the word.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder-subtractor: LSB-first, DIGIT bits per cycle through a registered carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_w(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [DIGIT-1:0] ds;
  logic             dcout;
  logic             dcmsb;
  logic             accept;

  assign accept = start && (state == IDLE || state == DONE);

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x        (opa[DIGIT-1:0]),
    .y        (opb[DIGIT-1:0]),
    .cin      (carry),
    .s        (ds),
    .cout     (dcout),
    .c_msb_in (dcmsb)
  );

  // New digit enters at the top so the word is LSB-aligned after NDIG steps.
  assign acc_nx = (acc >> DIGIT) | (WIDTH'(ds) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (accept) begin
      opa <= a;
      opb <= sub ? ~b : b;
      acc <= '0;
    end else if (state == RUN) begin
      opa <= opa >> DIGIT;
      opb <= opb >> DIGIT;
      acc <= acc_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            carry <= sub;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          carry <= dcout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= acc_nx;
            cout  <= dcout;
            ovf   <= dcmsb ^ dcout;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: bit-serial (DIGIT=1) and nibble-serial (DIGIT=4) instances.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, sub1, busy1, done1, cout1, ovf1;
  logic [7:0] a1, b1, sum1;
  logic       start4, sub4, busy4, done4, cout4, ovf4;
  logic [7:0] a4, b4, sum4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One DIGIT=1 operation: latency, busy length, busy/done exclusivity, result, single done.
  task automatic op1(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic ts, input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    int nbusy;
    int both;
    a1 = ta; b1 = tb; sub1 = ts; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 0; nbusy = 0; both = 0;
    while (!done1 && lat < 20) begin
      if (busy1) nbusy++;
      tick();
      lat++;
      if (busy1 && done1) both++;
    end
    check({tag, ":latency"}, lat, 8);
    check({tag, ":busy_cycles"}, nbusy, 8);
    check({tag, ":busy_and_done"}, both, 0);
    check({tag, ":sum"}, sum1, es);
    check({tag, ":cout"}, cout1, ec);
    check({tag, ":ovf"}, ovf1, eo);
    tick();
    check({tag, ":done_pulse"}, done1, 1'b0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    tick();
    tick();
    check("rst:busy", busy1, 1'b0);
    check("rst:done", done1, 1'b0);
    check("rst:sum", sum1, 8'h00);
    check("rst:cout", cout1, 1'b0);
    check("rst:ovf", ovf1, 1'b0);
    check("rst:busy4", busy4, 1'b0);
    rst = 1'b0;
    tick();

    op1("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    op1("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op1("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op1("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
    op1("sub_55_55", 8'h55, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);

    // Start during RUN and operand changes must not disturb the running operation.
    a1 = 8'h12; b1 = 8'h34; sub1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("ign:sum_held_in_run", sum1, 8'h00);
    ndone = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 3) begin
        start1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF; sub1 = 1'b1;
      end else begin
        start1 = 1'b0;
      end
      if (i == 5) a1 = 8'h00;
      tick();
      if (done1) begin
        ndone++;
        check("ign:done_cycle", i, 8);
        check("ign:sum", sum1, 8'h46);
      end
    end
    check("ign:done_count", ndone, 1);
    check("ign:sum_held_idle", sum1, 8'h46);
    check("ign:busy_idle", busy1, 1'b0);

    op1("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Asynchronous reset in the middle of RUN.
    a1 = 8'h7F; b1 = 8'h01; sub1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick(); tick();
    check("mid:busy_before", busy1, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mid:busy", busy1, 1'b0);
    check("mid:done", done1, 1'b0);
    check("mid:sum", sum1, 8'h00);
    check("mid:cout", cout1, 1'b0);
    check("mid:ovf", ovf1, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    op1("post_rst", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

    // DIGIT=4 with start held high through DONE for a back-to-back operation.
    a4 = 8'h3C; b4 = 8'h55; sub4 = 1'b0; start4 = 1'b1;
    tick();
    a4 = 8'h10; b4 = 8'h20; sub4 = 1'b1;
    check("d4:busy_k", busy4, 1'b1);
    tick();
    check("d4:busy_k1", busy4, 1'b1);
    check("d4:done_k1", done4, 1'b0);
    tick();
    check("d4:done1", done4, 1'b1);
    check("d4:busy_at_done1", busy4, 1'b0);
    check("d4:sum1", sum4, 8'h91);
    check("d4:cout1", cout4, 1'b0);
    check("d4:ovf1", ovf4, 1'b1);
    tick();
    start4 = 1'b0;
    check("d4:rebusy", busy4, 1'b1);
    check("d4:done_gap", done4, 1'b0);
    check("d4:sum_held", sum4, 8'h91);
    tick();
    check("d4:done_gap2", done4, 1'b0);
    tick();
    check("d4:done2", done4, 1'b1);
    check("d4:sum2", sum4, 8'hF0);
    check("d4:cout2", cout4, 1'b0);
    check("d4:ovf2", ovf4, 1'b0);
    tick();
    check("d4:done2_pulse", done4, 1'b0);
    check("d4:idle_busy", busy4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit/digit-serial adder-subtractor, the multi-bit sequential successor to the single-bit combinational adder in the arithmetic test area. It accepts two WIDTH-bit operands on a start pulse and processes DIGIT bits per clock from LSB to MSB through a registered carry. It then presents sum, carry-out and signed overflow with a one-cycle done pulse. It is intended as a low-area arithmetic unit driven by a simple controller or testbench.

## Interface
- WIDTH, 8: operand and result width in bits. Must be ≥ 2.
- DIGIT, 1: bits processed per cycle. WIDTH % DIGIT == 0 is required; an elaboration-time check fails otherwise.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = A+B, 1 = A−B; latched with the operands.
- a  input  WIDTH  operand A; latched on an accepted start.
- b  input  WIDTH  operand B; latched on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; the result becomes valid on this cycle.
- sum  output  WIDTH  result; held until the next accepted start completes.
- cout  output  1  carry out of the MSB. For subtraction, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- NDIG = WIDTH/DIGIT.
- States:
  - IDLE: start → RUN.
  - RUN: after NDIG digit steps → DONE.
  - DONE: start → RUN; else → IDLE.
- Accepted start:
  - opA ← a
  - opB ← sub ? ~b : b
  - carry ← sub
  - cnt ← 0
  - acc ← 0
- Each RUN cycle:
  - Add the low DIGIT bits of opA, opB and carry.
  - Shift the DIGIT-bit result into the top of acc; shift opA and opB right by DIGIT.
  - carry ← digit carry-out; cnt ← cnt+1.
- Final digit (cnt == NDIG−1):
  - Capture cout = digit carry-out.
  - Capture ovf = (carry into bit WIDTH−1) XOR (carry out).
  - Load sum from the completed accumulator.
  - Assert done.
- Arithmetic is modulo 2^WIDTH; no saturation.
- start in RUN is ignored. No queueing, no error flag.
- sum, cout and ovf update only at completion. They hold their values through IDLE and through a subsequent RUN.
- a, b and sub may change freely after the start cycle.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, sum = 0, cout = 0, ovf = 0, cnt = 0, carry = 0.
- Reset mid-RUN aborts the operation immediately and asynchronously; outputs return to their reset values.
- start sampled high at edge k in IDLE:
  - busy = 1 from k through k+NDIG−1.
  - done = 1 and the result valid for the cycle after edge k+NDIG.
  - Latency = NDIG cycles.
- Back-to-back: start held high in DONE is accepted at that edge.
  - busy re-asserts the next cycle.
  - Throughput is one result per NDIG+1 cycles.
- done is registered and high for exactly one cycle per completed operation.
- busy and done are never high together.

## Structure
- serial_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function for NDIG;
  - a function for the cnt width, $clog2(NDIG) with minimum 1.
- One sub-module, digit_adder: a combinational DIGIT-bit ripple adder.
  - Inputs: x, y, cin.
  - Outputs: s, cout, and c_msb_in (carry into its top bit), used for ovf.
  - Instantiated once.
- The FSM, shift registers, counter and output registers live in serial_adder.

## Test plan
- Basic add, WIDTH=8, DIGIT=1: a=8'h0F, b=8'h01, sub=0, start at cycle 0 → busy high for cycles 1–8, done at cycle 9, sum=8'h10, cout=0, ovf=0.
- Overflow and wrap:
  - 8'h7F+8'h01 → sum=8'h80, ovf=1, cout=0.
  - 8'hFF+8'h01 → sum=8'h00, cout=1, ovf=0.
- Subtract: 8'h00−8'h01 → sum=8'hFF, cout=0 (borrow), ovf=0; 8'h80−8'h01 → sum=8'h7F, ovf=1, cout=1.
- Ignored start and operand change: pulse start again mid-RUN with different a/b; change a during RUN → the first result is unchanged and exactly one done pulse occurs.
- Reset mid-operation: assert rst at RUN cycle 3 → busy, done, sum, cout and ovf read 0 immediately; after release a new start completes normally.
- DIGIT=4, WIDTH=8 plus back-to-back operation:
  - 8'h3C+8'h55 → sum=8'h91, ovf=1, done two cycles after start.
  - Holding start through DONE starts a second operation whose done arrives three cycles after the first.
